uart_frame_receiver: RTL and testbench

UART_FRAME_RECEIVER -- requirements
Module: uart_frame_receiver

---
 rtl/uart_frame_receiver_if.sv | 24 ++
 rtl/uart_frame_receiver.sv | 119 +++++++++++
 tb/tb_uart_frame_receiver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_receiver_if.sv
// Serial line and received-byte signals between the UART frame receiver and its consumer.
interface uart_frame_receiver_if;
  logic       rx;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output frame,
    output frame_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  frame,
    input  frame_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver: synchronizes rx, samples each bit mid-period, and reports
// good bytes with a frame_valid pulse or bad stop bits with a frame_err pulse.
module uart_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_frame_receiver_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       frame_q;
  logic             frame_valid_q;
  logic             frame_err_q;
  logic             busy_q;
  logic             rx_meta;
  logic             rx_s;

  // Two-stage synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM; pulses default low and are raised only at the stop-bit sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= 8'h00;
      frame_q       <= 8'h00;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            if (rx_s) begin
              frame_q       <= shift;
              frame_valid_q <= 1'b1;
            end else begin
              frame_err_q   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver: directed frames against an event-queue model
// of expected pulses (kind, byte, due cycle) plus literal spot checks.
module tb_uart_frame_receiver;

  localparam int unsigned BIT = 16;
  localparam int unsigned LAT = 2 + BIT / 2 + 9 * BIT;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    int unsigned due;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_valid = 0;
  int unsigned n_err = 0;
  int unsigned last_valid_cyc = 0;
  logic [7:0] exp_frame = 8'h00;
  ev_t evq[$];

  uart_frame_receiver_if bus();

  uart_frame_receiver #(.CLKS_PER_BIT(BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    tick(BIT);
  endtask

  // Queues the expected outcome, then drives start, 8 data bits LSB first, stop.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned t0);
    ev_t e;
    t0       = cyc;
    e.is_err = !stop;
    e.data   = d;
    e.due    = cyc + LAT;
    evq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    bus.rx = 1'b1;
  endtask

  // Per-cycle comparison of DUT outputs against the pulse queue and held frame.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      exp_frame = 8'h00;
      chk("rst_frame", 32'(bus.frame), 32'h00);
      chk("rst_pulses", 32'({bus.frame_valid, bus.frame_err}), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
    end else begin
      if (bus.frame_valid && bus.frame_err) chk("valid_and_err", 32'h1, 32'h0);
      if (bus.frame_valid || bus.frame_err) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", 32'({bus.frame_valid, bus.frame_err}), 32'h0);
        end else begin
          e = evq.pop_front();
          chk("pulse_kind", 32'(bus.frame_err), 32'(e.is_err));
          chk("pulse_time", 32'((cyc + 1 >= e.due) && (cyc <= e.due + 1)), 32'h1);
          if (bus.frame_valid) begin
            if (!e.is_err) exp_frame = e.data;
            last_valid_cyc = cyc;
            n_valid++;
          end else begin
            n_err++;
          end
        end
      end else if (evq.size() > 0 && cyc > evq[0].due + 1) begin
        chk("pulse_missing", 32'h0, 32'h1);
        void'(evq.pop_front());
      end
      chk("frame_hold", 32'(bus.frame), 32'(exp_frame));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    bus.rx = 1'b1;
    rst    = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(5);
    chk("post_rst_frame", 32'(bus.frame), 32'h00);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);

    // Short low glitch: rejected in START, no pulse, frame stays 0x00.
    bus.rx = 1'b0;
    tick(4);
    chk("glitch_busy_hi", 32'(bus.busy), 32'h1);
    bus.rx = 1'b1;
    tick(20);
    chk("glitch_busy_lo", 32'(bus.busy), 32'h0);
    chk("glitch_frame", 32'(bus.frame), 32'h00);
    chk("glitch_nopulse", n_valid + n_err, 32'h0);

    // Single good frame and its latency from the start edge.
    send_frame(8'hA5, 1'b1, t0);
    tick(4);
    chk("a5_frame", 32'(bus.frame), 32'hA5);
    chk("a5_count", n_valid, 32'd1);
    chk("a5_latency", 32'((last_valid_cyc >= t0 + 153) && (last_valid_cyc <= t0 + 155)), 32'h1);
    chk("a5_busy", 32'(bus.busy), 32'h0);
    chk("a5_noerr", n_err, 32'd0);
    tick(10);

    // Back-to-back frames with no idle gap.
    send_frame(8'h3C, 1'b1, t0);
    chk("b2b_first", 32'(bus.frame), 32'h3C);
    send_frame(8'hFF, 1'b1, t0);
    tick(4);
    chk("b2b_second", 32'(bus.frame), 32'hFF);
    chk("b2b_count", n_valid, 32'd3);
    tick(10);

    // Bad stop bit: error pulse, frame keeps 0xFF.
    send_frame(8'h5A, 1'b0, t0);
    tick(30);
    chk("err_count", n_err, 32'd1);
    chk("err_frame", 32'(bus.frame), 32'hFF);
    chk("err_novalid", n_valid, 32'd3);
    chk("err_busy", 32'(bus.busy), 32'h0);

    // Reset during bit 4 of 0x81 aborts the frame silently.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0);
    bus.rx = 1'b0;
    tick(8);
    rst = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("abort_count", n_valid + n_err, 32'd4);
    chk("abort_frame", 32'(bus.frame), 32'h00);
    chk("abort_busy", 32'(bus.busy), 32'h0);

    send_frame(8'h42, 1'b1, t0);
    tick(4);
    chk("after_rst_frame", 32'(bus.frame), 32'h42);
    chk("after_rst_count", n_valid, 32'd4);

    tick(20);
    chk("queue_drained", evq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
